fp_convert_ctrl: RTL

FP_CONVERT_CTRL -- requirements
Module: fp_convert_ctrl

---
 rtl/fp_convert_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fp_convert_ctrl.sv
// fp_convert_ctrl
// Converts a 12-bit two's-complement sample into an 8-bit float
// (S, E[2:0], F[3:0]) where value = (-1)^S x F x 2^E. Conversion is
// sequential: magnitude, one-bit-per-cycle normalisation, then rounding.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   D holds a sample to convert
//   in_ready   block can accept a sample (IDLE)
//   D          12-bit two's-complement sample
//   out_valid  S/E/F hold a completed result (DONE)
//   out_ready  consumer accepts the result
//   S, E, F    sign, exponent, significand of the result
//
// state | meaning
// IDLE  | waiting for a sample; in_ready high
// MAG   | take sign and absolute value of the latched sample
// NORM  | shift left until mag[10] set or exponent reaches 0
// ROUND | round on mag[6], register S/E/F
// DONE  | result presented; wait for out_ready

module fp_convert_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAG   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [11:0] d_lat;
  logic        s_work;
  // The magnitude never exceeds 0x7FF, so bit 11 is always zero and is
  // not stored.
  logic [10:0] mag;
  logic [2:0]  e_work;

  logic [10:0] mag_abs;
  logic        norm_done;
  logic [3:0]  f_pre;
  logic        r_bit;
  logic [3:0]  f_rnd;
  logic [2:0]  e_rnd;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // -0x800 has no 12-bit positive counterpart; clamp it to 0x7FF.
  always_comb begin
    mag_abs = d_lat[10:0];
    if (d_lat[11]) begin
      if (d_lat[10:0] == 11'd0) mag_abs = 11'h7FF;
      else                      mag_abs = ~d_lat[10:0] + 11'd1;
    end
  end

  assign norm_done = mag[10] || (e_work == 3'd0);
  assign f_pre     = mag[10:7];
  assign r_bit     = mag[6];

  // Round half up; a carry out of the significand renormalises to 1000
  // and bumps the exponent, unless the exponent is already at its top,
  // in which case the result saturates.
  always_comb begin
    f_rnd = f_pre;
    e_rnd = e_work;
    if (r_bit) begin
      if (f_pre != 4'hF) begin
        f_rnd = f_pre + 4'd1;
      end else if (e_work != 3'd7) begin
        f_rnd = 4'b1000;
        e_rnd = e_work + 3'd1;
      end else begin
        f_rnd = 4'hF;
        e_rnd = 3'd7;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = MAG;
      MAG:     next_state = NORM;
      NORM:    if (norm_done) next_state = ROUND;
      ROUND:   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_lat  <= 12'd0;
      s_work <= 1'b0;
      mag    <= 11'd0;
      e_work <= 3'd0;
      S      <= 1'b0;
      E      <= 3'd0;
      F      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) d_lat <= D;
        end
        MAG: begin
          s_work <= d_lat[11];
          mag    <= mag_abs;
          e_work <= 3'd7;
        end
        NORM: begin
          if (!norm_done) begin
            mag    <= {mag[9:0], 1'b0};
            e_work <= e_work - 3'd1;
          end
        end
        ROUND: begin
          S <= s_work;
          E <= e_rnd;
          F <= f_rnd;
        end
        default: ;
      endcase
    end
  end

endmodule
